// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the HH:MM:SS stopwatch/timer block.
package stopwatch_pkg;

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturate a minutes/seconds preset to its legal maximum.
  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v,
                                                     input logic [FIELD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Seconds tick generator: counts 0..CLK_HZ-1 while enabled, pulses tick on the wrap cycle.
module stopwatch_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned    CNT_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;

  // Holding the count while disabled keeps the partial second across a pause.
  always_ff @(posedge clk_100MHz) begin
    if (reset || restart) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/stopwatch_timer.sv
// Count-up stopwatch / count-down timer in HH:MM:SS with pause, preset load and done/overflow pulses.
// Define STOPWATCH_LAP_EN to enable the lap-freeze display feature.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned MAX_HOURS = 23,
  parameter int unsigned HOUR_W    = 5
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               mode_in,
  input  logic               clear,
  input  logic               load_preset,
  input  logic [HOUR_W-1:0]  preset_hour,
  input  logic [FIELD_W-1:0] preset_min,
  input  logic [FIELD_W-1:0] preset_sec,
  input  logic               lap_in,
  output logic [HOUR_W-1:0]  hour_out,
  output logic [FIELD_W-1:0] min_out,
  output logic [FIELD_W-1:0] sec_out,
  output logic               running,
  output logic               done,
  output logic               overflow,
  output logic               lap_active
);

  localparam logic [HOUR_W-1:0]  HOUR_MAX = HOUR_W'(MAX_HOURS);
  localparam logic [FIELD_W-1:0] SEC_LAST = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] MIN_LAST = FIELD_W'(MIN_MAX);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [HOUR_W-1:0]  hour_q, hour_d;
  logic [FIELD_W-1:0] min_q, min_d, sec_q, sec_d;
  logic               done_d, ovf_d, lap_act_d;
  logic               start_prev_q, start_edge;
  logic               tick, tick_restart;
  logic               live_zero, one_left;
  logic [HOUR_W-1:0]  ld_hour, disp_hour;
  logic [FIELD_W-1:0] ld_min, ld_sec, disp_min, disp_sec;

  assign start_edge = start_stop && !start_prev_q;
  assign live_zero  = (hour_q == '0) && (min_q == '0) && (sec_q == '0);
  assign one_left   = (hour_q == '0) && (min_q == '0) && (sec_q == FIELD_W'(1));

  assign ld_hour = (preset_hour > HOUR_MAX) ? HOUR_MAX : preset_hour;
  assign ld_min  = clamp_field(preset_min, MIN_LAST);
  assign ld_sec  = clamp_field(preset_sec, SEC_LAST);

  stopwatch_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (state_q == RUN),
    .restart    (tick_restart),
    .tick       (tick)
  );

  // Next-state and counter logic; priority clear > start edge > load.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    done_d       = 1'b0;
    ovf_d        = 1'b0;
    tick_restart = 1'b0;

    if (clear) begin
      state_d      = IDLE;
      mode_d       = UP;
      hour_d       = '0;
      min_d        = '0;
      sec_d        = '0;
      tick_restart = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_edge) begin
            // A down-count start from zero has nothing to time, so it is dropped.
            if (!(mode_in == DOWN && live_zero)) begin
              state_d      = RUN;
              mode_d       = mode_in;
              tick_restart = 1'b1;
            end
          end else if (load_preset) begin
            hour_d = ld_hour;
            min_d  = ld_min;
            sec_d  = ld_sec;
          end
        end

        RUN: begin
          if (tick) begin
            if (mode_q == DOWN) begin
              if (live_zero || one_left) begin
                hour_d  = '0;
                min_d   = '0;
                sec_d   = '0;
                done_d  = 1'b1;
                state_d = DONE;
              end else if (sec_q != '0) begin
                sec_d = sec_q - FIELD_W'(1);
              end else begin
                sec_d = SEC_LAST;
                if (min_q != '0) begin
                  min_d = min_q - FIELD_W'(1);
                end else begin
                  min_d  = MIN_LAST;
                  hour_d = hour_q - HOUR_W'(1);
                end
              end
            end else begin
              if (sec_q < SEC_LAST) begin
                sec_d = sec_q + FIELD_W'(1);
              end else begin
                sec_d = '0;
                if (min_q < MIN_LAST) begin
                  min_d = min_q + FIELD_W'(1);
                end else begin
                  min_d = '0;
                  if (hour_q < HOUR_MAX) begin
                    hour_d = hour_q + HOUR_W'(1);
                  end else begin
                    hour_d = '0;
                    ovf_d  = 1'b1;
                  end
                end
              end
            end
          end
          // The tick still lands when pausing on the same cycle so no second is lost.
          if (start_edge && (state_d == RUN)) begin
            state_d = PAUSE;
          end
        end

        PAUSE: begin
          if (start_edge) begin
            state_d = RUN;
          end else if (load_preset) begin
            hour_d = ld_hour;
            min_d  = ld_min;
            sec_d  = ld_sec;
          end
        end

        DONE: begin
          if (start_edge) begin
            state_d = IDLE;
          end else if (load_preset) begin
            state_d = IDLE;
            hour_d  = ld_hour;
            min_d   = ld_min;
            sec_d   = ld_sec;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [HOUR_W-1:0]  lap_hour_q, lap_hour_d;
  logic [FIELD_W-1:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;
  logic               lap_req;

  // Lap is the lowest-priority request; any same-cycle edge or accepted load drops it.
  assign lap_req = lap_in && !clear && !start_edge && !(load_preset && (state_q != RUN));

  always_comb begin
    lap_hour_d = lap_hour_q;
    lap_min_d  = lap_min_q;
    lap_sec_d  = lap_sec_q;
    lap_act_d  = lap_active;
    if (clear) begin
      lap_act_d = 1'b0;
    end else if (lap_req) begin
      if (state_q == RUN) begin
        lap_hour_d = hour_q;
        lap_min_d  = min_q;
        lap_sec_d  = sec_q;
        lap_act_d  = 1'b1;
      end else begin
        lap_act_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      lap_hour_q <= '0;
      lap_min_q  <= '0;
      lap_sec_q  <= '0;
    end else begin
      lap_hour_q <= lap_hour_d;
      lap_min_q  <= lap_min_d;
      lap_sec_q  <= lap_sec_d;
    end
  end

  assign disp_hour = lap_act_d ? lap_hour_d : hour_d;
  assign disp_min  = lap_act_d ? lap_min_d  : min_d;
  assign disp_sec  = lap_act_d ? lap_sec_d  : sec_d;
`else
  logic unused_lap;
  assign unused_lap = lap_in;
  assign lap_act_d  = 1'b0;
  assign disp_hour  = hour_d;
  assign disp_min   = min_d;
  assign disp_sec   = sec_d;
`endif

  // State, live count and registered outputs.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= UP;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      // Capture the level so a button held through reset is not seen as a start.
      start_prev_q <= start_stop;
      hour_out     <= '0;
      min_out      <= '0;
      sec_out      <= '0;
      running      <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      lap_active   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      start_prev_q <= start_stop;
      hour_out     <= disp_hour;
      min_out      <= disp_min;
      sec_out      <= disp_sec;
      running      <= (state_d == RUN);
      done         <= done_d;
      overflow     <= ovf_d;
      lap_active   <= lap_act_d;
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed self-checking bench for stopwatch_timer (CLK_HZ=4, MAX_HOURS=23); honours STOPWATCH_LAP_EN.
module tb_stopwatch_timer;

  localparam int unsigned CLK_HZ    = 4;
  localparam int unsigned MAX_HOURS = 23;
  localparam int unsigned HOUR_W    = 5;

  logic              clk = 1'b0;
  logic              reset, start_stop, mode_in, clear, load_preset, lap_in;
  logic [HOUR_W-1:0] preset_hour;
  logic [5:0]        preset_min, preset_sec;
  logic [HOUR_W-1:0] hour_out;
  logic [5:0]        min_out, sec_out;
  logic              running, done, overflow, lap_active;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(
    .CLK_HZ    (CLK_HZ),
    .MAX_HOURS (MAX_HOURS),
    .HOUR_W    (HOUR_W)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .start_stop  (start_stop),
    .mode_in     (mode_in),
    .clear       (clear),
    .load_preset (load_preset),
    .preset_hour (preset_hour),
    .preset_min  (preset_min),
    .preset_sec  (preset_sec),
    .lap_in      (lap_in),
    .hour_out    (hour_out),
    .min_out     (min_out),
    .sec_out     (sec_out),
    .running     (running),
    .done        (done),
    .overflow    (overflow),
    .lap_active  (lap_active)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    logic [HOUR_W+11:0] obs, exp;
    obs = {hour_out, min_out, sec_out};
    exp = {HOUR_W'(h), 6'(m), 6'(s)};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d:%0d:%0d expected %0d:%0d:%0d",
             tag, hour_out, min_out, sec_out, h, m, s);
    end
  endtask

  task automatic press();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    preset_hour = HOUR_W'(h);
    preset_min  = 6'(m);
    preset_sec  = 6'(s);
    load_preset = 1'b1;
    cyc(1);
    load_preset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; mode_in = 1'b0; clear = 1'b0;
    load_preset = 1'b0; lap_in = 1'b0;
    preset_hour = '0; preset_min = '0; preset_sec = '0;

    // Reset
    cyc(3);
    chk_time("reset_time", 0, 0, 0);
    chk_bit("reset_running", running, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_overflow", overflow, 1'b0);
    chk_bit("reset_lap", lap_active, 1'b0);
    reset = 1'b0;
    cyc(1);

    // First tick latency
    press();
    chk_bit("start_running", running, 1'b1);
    chk_time("start_t1", 0, 0, 0);
    cyc(3);
    chk_time("start_t4m1", 0, 0, 0);
    cyc(1);
    chk_time("start_t4", 0, 0, 1);
    cyc(4);
    chk_time("start_t8", 0, 0, 2);
    do_clear();
    chk_time("clear_time", 0, 0, 0);
    chk_bit("clear_running", running, 1'b0);

    // Up-count wrap with overflow
    do_load(23, 59, 58);
    chk_time("load_235958", 23, 59, 58);
    press();
    cyc(3);
    chk_time("ovf_t3", 23, 59, 58);
    cyc(1);
    chk_time("ovf_t4", 23, 59, 59);
    cyc(3);
    chk_bit("ovf_t7_pulse", overflow, 1'b0);
    cyc(1);
    chk_time("ovf_t8", 0, 0, 0);
    chk_bit("ovf_t8_pulse", overflow, 1'b1);
    chk_bit("ovf_t8_running", running, 1'b1);
    cyc(1);
    chk_bit("ovf_t9_pulse", overflow, 1'b0);
    chk_time("ovf_t9", 0, 0, 0);
    do_clear();

    // Preset clamp
    do_load(0, 63, 62);
    chk_time("clamp_ms", 0, 59, 59);
    do_load(31, 0, 0);
    chk_time("clamp_h", 23, 0, 0);
    do_load(24, 60, 59);
    chk_time("clamp_all", 23, 59, 59);
    do_load(23, 59, 59);
    chk_time("clamp_none", 23, 59, 59);

    // load_preset ignored in RUN
    do_clear();
    press();
    do_load(5, 5, 5);
    chk_time("runload_t1", 0, 0, 0);
    chk_bit("runload_running", running, 1'b1);
    cyc(3);
    chk_time("runload_t4", 0, 0, 1);

    // Pause holds count and tick fraction
    do_clear();
    press();
    cyc(5);
    press();
    chk_bit("pause_running", running, 1'b0);
    chk_time("pause_t6", 0, 0, 1);
    cyc(20);
    chk_time("pause_held", 0, 0, 1);
    chk_bit("pause_held_running", running, 1'b0);
    press();
    chk_bit("resume_running", running, 1'b1);
    chk_time("resume_t0", 0, 0, 1);
    cyc(1);
    chk_time("resume_t1", 0, 0, 1);
    cyc(1);
    chk_time("resume_t2", 0, 0, 2);

    // Down count to done
    do_clear();
    mode_in = 1'b1;
    do_load(0, 1, 1);
    press();
    mode_in = 1'b0;
    cyc(4);
    chk_time("down_t4", 0, 1, 0);
    cyc(4);
    chk_time("down_t8", 0, 0, 59);
    cyc(232);
    chk_time("down_t240", 0, 0, 1);
    chk_bit("down_t240_done", done, 1'b0);
    cyc(4);
    chk_time("down_t244", 0, 0, 0);
    chk_bit("down_t244_done", done, 1'b1);
    chk_bit("down_t244_running", running, 1'b0);
    cyc(1);
    chk_bit("down_t245_done", done, 1'b0);
    cyc(8);
    chk_time("down_hold", 0, 0, 0);
    chk_bit("down_hold_done", done, 1'b0);

    // DONE -> IDLE, then down-start from zero is ignored
    press();
    mode_in = 1'b1;
    cyc(1);
    press();
    chk_bit("zero_down_start", running, 1'b0);
    cyc(4);
    chk_bit("zero_down_idle", running, 1'b0);
    chk_time("zero_down_time", 0, 0, 0);
    mode_in = 1'b0;

    // Lap freeze
    do_clear();
    press();
    cyc(12);
    chk_time("lap_pre", 0, 0, 3);
    lap_in = 1'b1;
    cyc(1);
    lap_in = 1'b0;
    cyc(15);
`ifdef STOPWATCH_LAP_EN
    chk_bit("lap_active_on", lap_active, 1'b1);
    chk_time("lap_frozen", 0, 0, 3);
`else
    chk_bit("lap_active_off", lap_active, 1'b0);
    chk_time("lap_live", 0, 0, 7);
`endif
    press();
    chk_bit("lap_pause_running", running, 1'b0);
`ifdef STOPWATCH_LAP_EN
    chk_time("lap_pause_frozen", 0, 0, 3);
`endif
    lap_in = 1'b1;
    cyc(1);
    lap_in = 1'b0;
    chk_time("lap_release", 0, 0, 7);
    chk_bit("lap_release_active", lap_active, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
